trap_ctrl: RTL and testbench
============================

# trap_ctrl

Machine-mode trap controller for the RISC-V core. It arbitrates between synchronous exceptions reported by the commit stage and the three M-mode interrupt lines, and sequences the pipeline flush/redirect handshake. It owns the trap CSRs (mstatus trap fields, mepc, mcause, mtval) and the current privilege level, and also handles MRET and WFI. It sits beside the commit stage and the CSR file, which still owns mtvec and mie.

## Interface
- XLEN, 64, data/address width (RV_XLEN of riscv_pkg)
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- commit_valid_i  in  1  an instruction is at the commit point this cycle
- commit_pc_i  in  XLEN  PC of that instruction
- ex_valid_i  in  1  committing instruction raised a synchronous exception
- ex_cause_i  in  XLEN  ex_cause_t code (MSB=0)
- ex_tval_i  in  XLEN  trap value
- mret_i  in  1  committing instruction is MRET
- wfi_i  in  1  committing instruction is WFI
- irq_msi_i / irq_mti_i / irq_mei_i  in  1 each  level interrupt lines
- mie_i  in  XLEN  mie CSR
- mtvec_i  in  XLEN  mtvec CSR
- csr_we_i  in  1  CSR write strobe
- csr_addr_i  in  12  CSR address
- csr_wdata_i  in  XLEN  write data
- csr_rdata_o  out  XLEN  combinational read of csr_addr_i
- flush_o  out  1  request pipeline flush
- flush_ack_i  in  1  pipeline drained
- redirect_valid_o  out  1  one-cycle fetch redirect
- redirect_pc_o  out  XLEN  redirect target
- trap_o  out  1  pulse: trap entry committed
- stall_o  out  1  hold commit (WFI sleep or sequence in progress)
- priv_o  out  2  current priv_t

## Operation
- Owned CSRs: mstatus 0x300 (only MIE[3], MPIE[7], MPP[12:11] writable; others read 0; MPP write 2'b10 maps to 2'b00), mepc 0x341 (bits[1:0] forced 0), mcause 0x342, mtval 0x343, mip 0x344 (read-only: bit3=msi, bit7=mti, bit11=mei). Other addresses read 0.
- pend = mip & mie_i; global enable = (priv==U) or mstatus.MIE.
- Interrupt priority MEI(11) > MSI(3) > MTI(7).
- States: RUN, DRAIN, REDIRECT, SLEEP.
- RUN, commit_valid_i=1, evaluated in order:
  - enabled pend → take interrupt: mcause={1,code}, mepc=commit_pc_i, mtval=0. Interrupt preempts ex/mret/wfi in the same cycle.
  - else ex_valid_i → exception: mcause=ex_cause_i, mepc=commit_pc_i, mtval=ex_tval_i.
  - else mret_i → MRET.
  - else wfi_i → SLEEP.
- Trap/MRET info is latched in a pending register; state → DRAIN. A CSR write in the same cycle is dropped.
- DRAIN: flush_o=1, stall_o=1; held until flush_ack_i is sampled 1, then → REDIRECT.
- REDIRECT: one cycle, redirect_valid_o=1, then → RUN.
  - Trap target: mtvec_i[1:0]==01 and interrupt → {mtvec base}+4*code; otherwise base (mtvec_i & ~3).
  - MRET target: mepc.
  - CSR update at the end of the REDIRECT cycle:
    - trap: mepc, mcause, mtval written; MPIE←MIE; MIE←0; MPP←priv; priv←M; trap_o=1.
    - MRET: MIE←MPIE; MPIE←1; priv←MPP; MPP←U.
- SLEEP: stall_o=1; → RUN when pend≠0, regardless of global enable. An enabled interrupt is then taken by the normal RUN rule.
- CSR writes are accepted only in RUN.
- Reset in any state → RUN; the pending trap is discarded.

## Timing
- Reset values:
  - state RUN; priv M.
  - MIE, MPIE = 0; MPP = 00; mepc, mcause, mtval = 0.
  - flush_o, redirect_valid_o, trap_o, stall_o = 0; redirect_pc_o = 0.
- Detection in cycle N: flush_o high from N+1. If ack arrives in cycle K≥N+1, redirect_valid_o and trap_o are high in K+1, and the CSRs reflect the trap from K+2. Minimum detect-to-redirect latency is 2 cycles.
- flush_o stays asserted with no timeout; interrupt line changes during DRAIN do not alter the latched cause.
- redirect_valid_o is a single-cycle pulse; downstream must accept it (no backpressure).
- csr_rdata_o is combinational and reflects registered state (pre-update in the REDIRECT cycle).

## Test plan
- Reset, then read all five CSRs → 0. priv_o=11, all strobes 0.
- ex_valid_i with cause 2, commit_pc=0x1000, tval=0xdead, mtvec=0x8000, ack one cycle later:
  - flush_o high for 1 cycle, then redirect to 0x8000.
  - mepc=0x1000, mcause=2, mtval=0xdead, MIE 1→0 with MPIE=1.
- MTI and MEI pending and enabled, MIE=1, mtvec=0x8001, coincident with ex_valid_i → interrupt wins:
  - mcause=0x8000…000B, redirect 0x802C, mtval=0.
- From priv U, trap, then MRET → priv returns to 00, MIE restored to MPIE, MPP=00, redirect=mepc.
- WFI with MIE=0, then mti raised with mie[7]=1:
  - stall_o high until the line rises; no trap is taken; stall_o drops the next cycle.
- Hold flush_ack_i low 10 cycles, then assert rst_i:
  - flush_o drops, state is RUN, no redirect is issued, and CSRs are at reset values.
- Write mstatus with 0xFFFF… → reads back 0x1888 (MPP=11, MPIE, MIE). Write MPP=10 → MPP reads 00.

Source files
------------

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: arbitrates exceptions and M-mode interrupts, sequences the
// flush/redirect handshake, and owns mstatus trap fields, mepc, mcause, mtval and privilege.
module trap_ctrl #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            commit_valid_i,
  input  logic [XLEN-1:0] commit_pc_i,
  input  logic            ex_valid_i,
  input  logic [XLEN-1:0] ex_cause_i,
  input  logic [XLEN-1:0] ex_tval_i,
  input  logic            mret_i,
  input  logic            wfi_i,
  input  logic            irq_msi_i,
  input  logic            irq_mti_i,
  input  logic            irq_mei_i,
  input  logic [XLEN-1:0] mie_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic            csr_we_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            flush_o,
  input  logic            flush_ack_i,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            trap_o,
  output logic            stall_o,
  output logic [1:0]      priv_o
);

  typedef enum logic [1:0] {StRun, StDrain, StRedirect, StSleep} state_e;

  localparam logic [1:0]  PrivU       = 2'b00;
  localparam logic [1:0]  PrivM       = 2'b11;
  localparam logic [11:0] AddrMstatus = 12'h300;
  localparam logic [11:0] AddrMepc    = 12'h341;
  localparam logic [11:0] AddrMcause  = 12'h342;
  localparam logic [11:0] AddrMtval   = 12'h343;
  localparam logic [11:0] AddrMip     = 12'h344;

  state_e          state_q, state_d;
  logic [1:0]      priv_q, priv_d, mpp_q, mpp_d;
  logic            mie_q, mie_d, mpie_q, mpie_d;
  logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
  logic            pend_trap_q, pend_trap_d, pend_irq_q, pend_irq_d;
  logic [XLEN-1:0] pend_cause_q, pend_cause_d, pend_epc_q, pend_epc_d;
  logic [XLEN-1:0] pend_tval_q, pend_tval_d;
  logic            flush_q, flush_d, stall_q, stall_d;
  logic            redirect_valid_q, redirect_valid_d, trap_q, trap_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

  logic [XLEN-1:0] mip, pend, mstatus, trap_base, trap_target;
  logic            irq_take;
  logic [3:0]      irq_code;

  assign mip      = XLEN'({irq_mei_i, 3'b000, irq_mti_i, 3'b000, irq_msi_i, 3'b000});
  assign pend     = mip & mie_i;
  assign irq_take = ((priv_q == PrivU) || mie_q) && (pend != '0);
  assign mstatus  = XLEN'({mpp_q, 3'b000, mpie_q, 3'b000, mie_q, 3'b000});

  always_comb begin
    if (pend[11])     irq_code = 4'd11;
    else if (pend[3]) irq_code = 4'd3;
    else              irq_code = 4'd7;
  end

  // Vectored mode only applies to interrupts; the latched cause low bits hold the code.
  assign trap_base   = {mtvec_i[XLEN-1:2], 2'b00};
  assign trap_target = (pend_irq_q && (mtvec_i[1:0] == 2'b01)) ?
                       trap_base + (XLEN'(pend_cause_q[3:0]) << 2) : trap_base;

  always_comb begin
    case (csr_addr_i)
      AddrMstatus: csr_rdata_o = mstatus;
      AddrMepc:    csr_rdata_o = mepc_q;
      AddrMcause:  csr_rdata_o = mcause_q;
      AddrMtval:   csr_rdata_o = mtval_q;
      AddrMip:     csr_rdata_o = mip;
      default:     csr_rdata_o = '0;
    endcase
  end

  always_comb begin
    state_d          = state_q;
    priv_d           = priv_q;
    mpp_d            = mpp_q;
    mie_d            = mie_q;
    mpie_d           = mpie_q;
    mepc_d           = mepc_q;
    mcause_d         = mcause_q;
    mtval_d          = mtval_q;
    pend_trap_d      = pend_trap_q;
    pend_irq_d       = pend_irq_q;
    pend_cause_d     = pend_cause_q;
    pend_epc_d       = pend_epc_q;
    pend_tval_d      = pend_tval_q;
    flush_d          = 1'b0;
    stall_d          = 1'b0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = '0;
    trap_d           = 1'b0;

    case (state_q)
      StRun: begin
        if (commit_valid_i && (irq_take || ex_valid_i || mret_i)) begin
          state_d     = StDrain;
          flush_d     = 1'b1;
          stall_d     = 1'b1;
          pend_trap_d = irq_take || ex_valid_i;
          pend_irq_d  = irq_take;
          pend_epc_d  = commit_pc_i;
          if (irq_take) begin
            pend_cause_d = {1'b1, (XLEN-1)'(irq_code)};
            pend_tval_d  = '0;
          end else begin
            pend_cause_d = ex_cause_i;
            pend_tval_d  = ex_tval_i;
          end
        end else if (commit_valid_i && wfi_i) begin
          state_d = StSleep;
          stall_d = 1'b1;
        end else if (csr_we_i) begin
          case (csr_addr_i)
            AddrMstatus: begin
              mie_d  = csr_wdata_i[3];
              mpie_d = csr_wdata_i[7];
              mpp_d  = (csr_wdata_i[12:11] == 2'b10) ? PrivU : csr_wdata_i[12:11];
            end
            AddrMepc:   mepc_d   = {csr_wdata_i[XLEN-1:2], 2'b00};
            AddrMcause: mcause_d = csr_wdata_i;
            AddrMtval:  mtval_d  = csr_wdata_i;
            default: ;
          endcase
        end
      end
      StDrain: begin
        stall_d = 1'b1;
        if (flush_ack_i) begin
          state_d          = StRedirect;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = pend_trap_q ? trap_target : mepc_q;
          trap_d           = pend_trap_q;
        end else begin
          flush_d = 1'b1;
        end
      end
      StRedirect: begin
        state_d = StRun;
        if (pend_trap_q) begin
          mepc_d   = {pend_epc_q[XLEN-1:2], 2'b00};
          mcause_d = pend_cause_q;
          mtval_d  = pend_tval_q;
          mpie_d   = mie_q;
          mie_d    = 1'b0;
          mpp_d    = priv_q;
          priv_d   = PrivM;
        end else begin
          mie_d  = mpie_q;
          mpie_d = 1'b1;
          priv_d = mpp_q;
          mpp_d  = PrivU;
        end
      end
      StSleep: begin
        // Wake on any pending line; whether it traps is decided back in RUN.
        if (pend != '0) begin
          state_d = StRun;
        end else begin
          stall_d = 1'b1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= StRun;
      priv_q           <= PrivM;
      mpp_q            <= PrivU;
      mie_q            <= 1'b0;
      mpie_q           <= 1'b0;
      mepc_q           <= '0;
      mcause_q         <= '0;
      mtval_q          <= '0;
      pend_trap_q      <= 1'b0;
      pend_irq_q       <= 1'b0;
      pend_cause_q     <= '0;
      pend_epc_q       <= '0;
      pend_tval_q      <= '0;
      flush_q          <= 1'b0;
      stall_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      trap_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      priv_q           <= priv_d;
      mpp_q            <= mpp_d;
      mie_q            <= mie_d;
      mpie_q           <= mpie_d;
      mepc_q           <= mepc_d;
      mcause_q         <= mcause_d;
      mtval_q          <= mtval_d;
      pend_trap_q      <= pend_trap_d;
      pend_irq_q       <= pend_irq_d;
      pend_cause_q     <= pend_cause_d;
      pend_epc_q       <= pend_epc_d;
      pend_tval_q      <= pend_tval_d;
      flush_q          <= flush_d;
      stall_q          <= stall_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      trap_q           <= trap_d;
    end
  end

  assign flush_o          = flush_q;
  assign stall_o          = stall_q;
  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_pc_q;
  assign trap_o           = trap_q;
  assign priv_o           = priv_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: a transaction-level model checked every cycle plus directed literal checks.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_i, commit_valid_i, ex_valid_i, mret_i, wfi_i;
  logic        irq_msi_i, irq_mti_i, irq_mei_i, csr_we_i, flush_ack_i;
  logic [63:0] commit_pc_i, ex_cause_i, ex_tval_i, mie_i, mtvec_i, csr_wdata_i;
  logic [11:0] csr_addr_i;
  logic [63:0] csr_rdata_o, redirect_pc_o;
  logic        flush_o, redirect_valid_o, trap_o, stall_o;
  logic [1:0]  priv_o;

  int tests = 0;
  int fails = 0;

  always #10 clk = ~clk;

  trap_ctrl #(.XLEN(64)) dut (
    .clk_i(clk), .rst_i(rst_i), .commit_valid_i(commit_valid_i), .commit_pc_i(commit_pc_i),
    .ex_valid_i(ex_valid_i), .ex_cause_i(ex_cause_i), .ex_tval_i(ex_tval_i), .mret_i(mret_i),
    .wfi_i(wfi_i), .irq_msi_i(irq_msi_i), .irq_mti_i(irq_mti_i), .irq_mei_i(irq_mei_i),
    .mie_i(mie_i), .mtvec_i(mtvec_i), .csr_we_i(csr_we_i), .csr_addr_i(csr_addr_i),
    .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o), .flush_o(flush_o),
    .flush_ack_i(flush_ack_i), .redirect_valid_o(redirect_valid_o),
    .redirect_pc_o(redirect_pc_o), .trap_o(trap_o), .stall_o(stall_o), .priv_o(priv_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: architectural CSRs plus "what the pipeline handshake is doing right now".
  logic [63:0] m_mst = '0, m_mepc = '0, m_mcause = '0, m_mtval = '0;
  logic [1:0]  m_priv = 2'b11;
  bit          m_wait = 0, m_redir = 0, m_sleep = 0, r_trap = 0, r_irq = 0;
  logic [63:0] r_cause = '0, r_epc = '0, r_tval = '0, r_target = '0;
  int          r_code = 0;

  function automatic logic [63:0] m_mip();
    return {52'b0, irq_mei_i, 3'b0, irq_mti_i, 3'b0, irq_msi_i, 3'b0};
  endfunction

  function automatic logic [63:0] m_csr(input logic [11:0] a);
    case (a)
      12'h300: return m_mst;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return m_mip();
      default: return 64'h0;
    endcase
  endfunction

  task automatic model_step();
    logic [63:0] pend;
    logic [1:0]  np;
    pend = m_mip() & mie_i;
    if (rst_i) begin
      m_mst = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0; m_priv = 2'b11;
      m_wait = 0; m_redir = 0; m_sleep = 0;
    end else if (m_redir) begin
      m_redir = 0;
      if (r_trap) begin
        m_mepc   = r_epc & ~64'h3;
        m_mcause = r_cause;
        m_mtval  = r_tval;
        m_mst    = {51'b0, m_priv, 11'b0} | (m_mst[3] ? 64'h80 : 64'h0);
        m_priv   = 2'b11;
      end else begin
        np     = m_mst[12:11];
        m_mst  = 64'h80 | (m_mst[7] ? 64'h8 : 64'h0);
        m_priv = np;
      end
    end else if (m_wait) begin
      if (flush_ack_i) begin
        m_wait  = 0;
        m_redir = 1;
        if (!r_trap) r_target = m_mepc;
        else if (r_irq && mtvec_i[1:0] == 2'b01) r_target = (mtvec_i & ~64'h3) + 64'(4 * r_code);
        else r_target = mtvec_i & ~64'h3;
      end
    end else if (m_sleep) begin
      if (pend != 0) m_sleep = 0;
    end else if (commit_valid_i && (m_priv == 2'b00 || m_mst[3]) && pend != 0) begin
      r_code  = pend[11] ? 11 : (pend[3] ? 3 : 7);
      r_trap  = 1; r_irq = 1;
      r_cause = 64'h8000_0000_0000_0000 + 64'(r_code);
      r_epc   = commit_pc_i; r_tval = 0; m_wait = 1;
    end else if (commit_valid_i && ex_valid_i) begin
      r_trap = 1; r_irq = 0; r_cause = ex_cause_i; r_epc = commit_pc_i; r_tval = ex_tval_i;
      m_wait = 1;
    end else if (commit_valid_i && mret_i) begin
      r_trap = 0; r_irq = 0; m_wait = 1;
    end else if (commit_valid_i && wfi_i) begin
      m_sleep = 1;
    end else if (csr_we_i) begin
      case (csr_addr_i)
        12'h300: begin
          m_mst = csr_wdata_i & 64'h1888;
          if (csr_wdata_i[12:11] == 2'b10) m_mst[12:11] = 2'b00;
        end
        12'h341: m_mepc   = csr_wdata_i & ~64'h3;
        12'h342: m_mcause = csr_wdata_i;
        12'h343: m_mtval  = csr_wdata_i;
        default: ;
      endcase
    end
  endtask

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("cyc_flush", 64'(flush_o), 64'(m_wait));
      chk("cyc_stall", 64'(stall_o), 64'(m_wait | m_redir | m_sleep));
      chk("cyc_redirect_valid", 64'(redirect_valid_o), 64'(m_redir));
      chk("cyc_trap", 64'(trap_o), 64'(m_redir & r_trap));
      chk("cyc_priv", 64'(priv_o), 64'(m_priv));
      chk("cyc_csr_rdata", csr_rdata_o, m_csr(csr_addr_i));
      if (m_redir) chk("cyc_redirect_pc", redirect_pc_o, r_target);
      model_step();
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a, input logic [63:0] exp, input string name);
    csr_addr_i = a;
    #1;
    chk(name, csr_rdata_o, exp);
  endtask

  task automatic wr(input logic [11:0] a, input logic [63:0] d);
    csr_we_i = 1; csr_addr_i = a; csr_wdata_i = d;
    cyc();
    csr_we_i = 0;
  endtask

  task automatic commit(input logic [63:0] pc, input bit ex, input logic [63:0] cause,
                        input logic [63:0] tval, input bit mr, input bit wf);
    commit_valid_i = 1; commit_pc_i = pc; ex_valid_i = ex; ex_cause_i = cause;
    ex_tval_i = tval; mret_i = mr; wfi_i = wf;
    cyc();
    commit_valid_i = 0; ex_valid_i = 0; mret_i = 0; wfi_i = 0;
  endtask

  task automatic ack();
    flush_ack_i = 1;
    cyc();
    flush_ack_i = 0;
  endtask

  initial begin
    rst_i = 1; commit_valid_i = 0; ex_valid_i = 0; mret_i = 0; wfi_i = 0;
    irq_msi_i = 0; irq_mti_i = 0; irq_mei_i = 0; csr_we_i = 0; flush_ack_i = 0;
    commit_pc_i = 0; ex_cause_i = 0; ex_tval_i = 0; mie_i = 0; mtvec_i = 64'h8000;
    csr_wdata_i = 0; csr_addr_i = 12'h300;
    repeat (3) cyc();
    rst_i = 0;
    rd(12'h300, 0, "rst_mstatus"); rd(12'h341, 0, "rst_mepc"); rd(12'h342, 0, "rst_mcause");
    rd(12'h343, 0, "rst_mtval"); rd(12'h344, 0, "rst_mip");
    chk("rst_priv", 64'(priv_o), 64'h3); chk("rst_flush", 64'(flush_o), 0);
    chk("rst_redirect", 64'(redirect_valid_o), 0); chk("rst_trap", 64'(trap_o), 0);
    chk("rst_stall", 64'(stall_o), 0);
    cyc();

    // Synchronous exception, ack one cycle after detection
    wr(12'h300, 64'h8);
    commit(64'h1000, 1, 64'd2, 64'hdead, 0, 0);
    chk("ex_flush", 64'(flush_o), 1);
    ack();
    chk("ex_flush_drop", 64'(flush_o), 0);
    chk("ex_redirect", 64'(redirect_valid_o), 1);
    chk("ex_redirect_pc", redirect_pc_o, 64'h8000);
    chk("ex_trap", 64'(trap_o), 1);
    cyc();
    chk("ex_redirect_pulse", 64'(redirect_valid_o), 0);
    rd(12'h341, 64'h1000, "ex_mepc"); rd(12'h342, 64'd2, "ex_mcause");
    rd(12'h343, 64'hdead, "ex_mtval"); rd(12'h300, 64'h1880, "ex_mstatus");

    // Interrupt beats a coincident exception; MEI outranks MTI; vectored target
    wr(12'h300, 64'h8);
    mie_i = 64'h880; mtvec_i = 64'h8001; irq_mti_i = 1; irq_mei_i = 1;
    commit(64'h1100, 1, 64'd5, 64'h77, 0, 0);
    irq_mei_i = 0;
    cyc();
    ack();
    irq_mti_i = 0;
    chk("irq_redirect_pc", redirect_pc_o, 64'h802C);
    chk("irq_trap", 64'(trap_o), 1);
    cyc();
    rd(12'h342, 64'h8000_0000_0000_000B, "irq_mcause");
    rd(12'h343, 64'h0, "irq_mtval"); rd(12'h341, 64'h1100, "irq_mepc");

    // MRET into U, trap from U, MRET back to U
    mtvec_i = 64'h8000;
    wr(12'h341, 64'h2003);
    rd(12'h341, 64'h2000, "mepc_align");
    wr(12'h300, 64'h80);
    commit(64'h1200, 0, 0, 0, 1, 0);
    ack();
    chk("mret1_pc", redirect_pc_o, 64'h2000); chk("mret1_trap", 64'(trap_o), 0);
    cyc();
    chk("mret1_priv", 64'(priv_o), 0); rd(12'h300, 64'h88, "mret1_mstatus");
    commit(64'h3000, 1, 64'd8, 0, 0, 0);
    ack();
    chk("utrap_pc", redirect_pc_o, 64'h8000);
    cyc();
    chk("utrap_priv", 64'(priv_o), 3); rd(12'h300, 64'h80, "utrap_mstatus");
    commit(64'h3004, 0, 0, 0, 1, 0);
    ack();
    chk("mret2_pc", redirect_pc_o, 64'h3000);
    cyc();
    chk("mret2_priv", 64'(priv_o), 0); rd(12'h300, 64'h88, "mret2_mstatus");

    // Back to M, WFI with MIE=0, wake on MTI without trapping
    commit(64'h4000, 1, 64'd8, 0, 0, 0);
    ack();
    cyc();
    wr(12'h300, 64'h0);
    commit(64'h4004, 0, 0, 0, 0, 1);
    chk("wfi_stall", 64'(stall_o), 1);
    repeat (3) cyc();
    chk("wfi_stall_hold", 64'(stall_o), 1);
    irq_mti_i = 1;
    cyc();
    chk("wfi_wake_stall", 64'(stall_o), 0);
    commit(64'h4008, 0, 0, 0, 0, 0);
    chk("wfi_no_trap", 64'(flush_o), 0);
    irq_mti_i = 0;
    cyc();

    // Ack withheld, then reset mid-drain
    commit(64'h5000, 1, 64'd4, 64'h11, 0, 0);
    repeat (10) cyc();
    chk("drain_flush_held", 64'(flush_o), 1);
    rst_i = 1;
    cyc();
    rst_i = 0;
    chk("rst_drain_flush", 64'(flush_o), 0); chk("rst_drain_redirect", 64'(redirect_valid_o), 0);
    chk("rst_drain_priv", 64'(priv_o), 3);
    rd(12'h300, 0, "rst2_mstatus"); rd(12'h341, 0, "rst2_mepc");
    rd(12'h342, 0, "rst2_mcause"); rd(12'h343, 0, "rst2_mtval");
    repeat (3) cyc();
    chk("rst_drain_no_redirect", 64'(redirect_valid_o), 0);

    // mstatus write masking and WARL MPP
    wr(12'h300, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(12'h300, 64'h1888, "mstatus_ones");
    wr(12'h300, 64'h1088);
    rd(12'h300, 64'h88, "mstatus_mpp10");
    wr(12'h342, 64'h55);
    wr(12'h344, 64'h5);
    rd(12'h342, 64'h55, "mcause_wr"); rd(12'h344, 64'h0, "mip_ro"); rd(12'h305, 64'h0, "unmapped");
    repeat (2) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
